// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one CPU word/byte access onto split byte-lane memory,
// with wait states, misalignment faults, data breakpoints and a saturating access counter.
module mem_access_unit #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_byte_acc,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [15:0]       o_rdata,
  output logic [ADDR_W-1:0] o_mem_lb_addr,
  output logic [ADDR_W-1:0] o_mem_ub_addr,
  output logic [7:0]        o_mem_lb_wdata,
  output logic [7:0]        o_mem_ub_wdata,
  output logic              o_mem_lb_we,
  output logic              o_mem_ub_we,
  input  logic [7:0]        i_mem_lb_rdata,
  input  logic [7:0]        i_mem_ub_rdata,
  input  logic              i_bkpt_en,
  input  logic [1:0]        i_bkpt_mode,
  input  logic [ADDR_W-1:0] i_bkpt_addr,
  output logic              o_bkpt_hit,
  output logic [CNT_W-1:0]  o_acc_count,
  input  logic              i_cnt_clr
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  state_t            r_state, w_next;
  logic              r_we, r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wcnt;
  logic              w_start, w_misalign, w_lb_sel, w_ub_sel, w_ok_done, w_hit;
  logic [15:0]       w_rdata;
  logic [CNT_W-1:0]  w_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:   w_next = i_req ? (w_misalign ? S_DONE : S_ACCESS) : S_IDLE;
      S_ACCESS: w_next = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
      S_WAIT:   w_next = (r_wcnt == 4'(WAIT_STATES - 1)) ? S_DONE : S_WAIT;
      S_DONE:   w_next = S_IDLE;
    endcase
  end

  // Only a misaligned request jumps IDLE->DONE, so any other DONE entry is a good access.
  always_comb begin
    w_start    = (r_state == S_IDLE) && i_req;
    w_misalign = !i_byte_acc && i_addr[0];
    w_lb_sel   = !i_byte_acc || !i_addr[0];
    w_ub_sel   = !i_byte_acc || i_addr[0];
    w_ok_done  = (w_next == S_DONE) && (r_state != S_IDLE);
    w_hit      = i_bkpt_en && w_ok_done && (r_addr[ADDR_W-1:1] == i_bkpt_addr[ADDR_W-1:1])
                 && (!r_byte || r_addr[0] == i_bkpt_addr[0]) && (r_we ? i_bkpt_mode[1] : i_bkpt_mode[0]);
    w_rdata    = r_byte ? {8'h00, r_addr[0] ? i_mem_ub_rdata : i_mem_lb_rdata}
                        : {i_mem_ub_rdata, i_mem_lb_rdata};
    w_cnt      = i_cnt_clr ? '0 : (w_ok_done && !(&o_acc_count)) ? o_acc_count + 1'b1 : o_acc_count;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_fault        <= 1'b0;
      o_bkpt_hit     <= 1'b0;
      o_mem_lb_we    <= 1'b0;
      o_mem_ub_we    <= 1'b0;
      o_rdata        <= '0;
      o_mem_lb_addr  <= '0;
      o_mem_ub_addr  <= '0;
      o_mem_lb_wdata <= '0;
      o_mem_ub_wdata <= '0;
      o_acc_count    <= '0;
      r_we           <= 1'b0;
      r_byte         <= 1'b0;
      r_addr         <= '0;
      r_wcnt         <= '0;
    end else begin
      o_busy      <= w_next != S_IDLE;
      o_done      <= w_next == S_DONE;
      o_fault     <= (w_next == S_DONE) && (r_state == S_IDLE);
      o_bkpt_hit  <= w_hit;
      o_mem_lb_we <= w_start && !w_misalign && i_we && w_lb_sel;
      o_mem_ub_we <= w_start && !w_misalign && i_we && w_ub_sel;
      o_acc_count <= w_cnt;
      r_wcnt      <= (r_state == S_WAIT) ? r_wcnt + 4'd1 : 4'd0;
      if (w_start) begin
        r_we   <= i_we;
        r_byte <= i_byte_acc;
        r_addr <= i_addr;
      end
      if (w_start && !w_misalign) begin
        o_mem_lb_addr <= {i_addr[ADDR_W-1:1], 1'b0};
        o_mem_ub_addr <= {i_addr[ADDR_W-1:1], 1'b1};
        if (i_we && w_lb_sel) o_mem_lb_wdata <= i_wdata[7:0];
        if (i_we && w_ub_sel) o_mem_ub_wdata <= i_byte_acc ? i_wdata[7:0] : i_wdata[15:8];
      end
      if (w_ok_done && !r_we) o_rdata <= w_rdata;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: two instances (no wait states / 3 wait states with a 2-bit counter)
// driven through a shared access task and checked against a byte-array reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, b_rst_n, a_req, b_req, we, byte_acc, bkpt_en, cnt_clr, sel;
  logic [15:0] addr, wdata, bkpt_addr;
  logic [1:0] bkpt_mode;
  logic a_busy, a_done, a_fault, a_hit, a_lb_we, a_ub_we;
  logic b_busy, b_done, b_fault, b_hit, b_lb_we, b_ub_we;
  logic [15:0] a_rdata, a_lb_addr, a_ub_addr, b_rdata, b_lb_addr, b_ub_addr, a_cnt;
  logic [7:0] a_lb_wd, a_ub_wd, a_lb_rd, a_ub_rd, b_lb_wd, b_ub_wd, b_lb_rd, b_ub_rd;
  logic [1:0] b_cnt;
  logic [7:0] mem_a [65536];
  logic [7:0] mem_b [65536];
  logic [7:0] ref_a [65536];

  mem_access_unit #(.ADDR_W(16), .WAIT_STATES(0), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_req(a_req), .i_we(we), .i_byte_acc(byte_acc),
    .i_addr(addr), .i_wdata(wdata), .o_busy(a_busy), .o_done(a_done), .o_fault(a_fault),
    .o_rdata(a_rdata), .o_mem_lb_addr(a_lb_addr), .o_mem_ub_addr(a_ub_addr),
    .o_mem_lb_wdata(a_lb_wd), .o_mem_ub_wdata(a_ub_wd), .o_mem_lb_we(a_lb_we), .o_mem_ub_we(a_ub_we),
    .i_mem_lb_rdata(a_lb_rd), .i_mem_ub_rdata(a_ub_rd), .i_bkpt_en(bkpt_en), .i_bkpt_mode(bkpt_mode),
    .i_bkpt_addr(bkpt_addr), .o_bkpt_hit(a_hit), .o_acc_count(a_cnt), .i_cnt_clr(cnt_clr));

  mem_access_unit #(.ADDR_W(16), .WAIT_STATES(3), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_req(b_req), .i_we(we), .i_byte_acc(byte_acc),
    .i_addr(addr), .i_wdata(wdata), .o_busy(b_busy), .o_done(b_done), .o_fault(b_fault),
    .o_rdata(b_rdata), .o_mem_lb_addr(b_lb_addr), .o_mem_ub_addr(b_ub_addr),
    .o_mem_lb_wdata(b_lb_wd), .o_mem_ub_wdata(b_ub_wd), .o_mem_lb_we(b_lb_we), .o_mem_ub_we(b_ub_we),
    .i_mem_lb_rdata(b_lb_rd), .i_mem_ub_rdata(b_ub_rd), .i_bkpt_en(bkpt_en), .i_bkpt_mode(bkpt_mode),
    .i_bkpt_addr(bkpt_addr), .o_bkpt_hit(b_hit), .o_acc_count(b_cnt), .i_cnt_clr(cnt_clr));

  always @(posedge clk) begin
    if (a_lb_we) mem_a[a_lb_addr] <= a_lb_wd;
    if (a_ub_we) mem_a[a_ub_addr] <= a_ub_wd;
    if (b_lb_we) mem_b[b_lb_addr] <= b_lb_wd;
    if (b_ub_we) mem_b[b_ub_addr] <= b_ub_wd;
  end
  assign a_lb_rd = mem_a[a_lb_addr];
  assign a_ub_rd = mem_a[a_ub_addr];
  assign b_lb_rd = mem_b[b_lb_addr];
  assign b_ub_rd = mem_b[b_ub_addr];

  logic s_done, s_fault, s_hit, s_lb_we, s_ub_we;
  logic [7:0] s_lb_wd, s_ub_wd;
  logic [15:0] s_lb_addr, s_ub_addr;
  assign s_done    = sel ? b_done : a_done;
  assign s_fault   = sel ? b_fault : a_fault;
  assign s_hit     = sel ? b_hit : a_hit;
  assign s_lb_we   = sel ? b_lb_we : a_lb_we;
  assign s_ub_we   = sel ? b_ub_we : a_ub_we;
  assign s_lb_wd   = sel ? b_lb_wd : a_lb_wd;
  assign s_ub_wd   = sel ? b_ub_wd : a_ub_wd;
  assign s_lb_addr = sel ? b_lb_addr : a_lb_addr;
  assign s_ub_addr = sel ? b_ub_addr : a_ub_addr;

  int total = 0, bad = 0, exp_a = 0, lat, nstb;
  logic f_o, h_o, slw, suw;
  logic [7:0] lwd, uwd;
  logic [15:0] la, ua;

  // One access on the selected instance; records latency, strobes and done-cycle flags.
  task automatic run(input logic w, input logic b, input logic [15:0] ad, input logic [15:0] wd, input int clr_at);
    @(posedge clk); #1;
    we = w; byte_acc = b; addr = ad; wdata = wd;
    if (sel) b_req = 1'b1; else a_req = 1'b1;
    lat = 0; nstb = 0; slw = 0; suw = 0; lwd = 0; uwd = 0; la = 0; ua = 0;
    do begin
      cnt_clr = (lat + 1 == clr_at);
      @(posedge clk); #1;
      a_req = 0; b_req = 0; lat++;
      if (lat == 1) begin la = s_lb_addr; ua = s_ub_addr; end
      if (s_lb_we || s_ub_we) begin nstb++; slw = s_lb_we; suw = s_ub_we; lwd = s_lb_wd; uwd = s_ub_wd; end
    end while (!s_done && lat < 40);
    cnt_clr = 0; f_o = s_fault; h_o = s_hit;
  endtask

  task automatic test_reset();
    a_rst_n = 0; b_rst_n = 0; a_req = 0; b_req = 0; we = 0; byte_acc = 0; bkpt_en = 0; cnt_clr = 0;
    sel = 0; addr = 0; wdata = 0; bkpt_addr = 0; bkpt_mode = 0;
    #12;
    total++; if ({a_busy, a_done, a_fault, a_hit, a_lb_we, a_ub_we} !== 6'b0) begin bad++; $display("FAIL reset_a_flags: got %b want 0", {a_busy, a_done, a_fault, a_hit, a_lb_we, a_ub_we}); end
    total++; if ({a_rdata, a_lb_addr, a_ub_addr, a_lb_wd, a_ub_wd, a_cnt} !== 80'h0) begin bad++; $display("FAIL reset_a_data: got %h want 0", {a_rdata, a_lb_addr, a_ub_addr, a_lb_wd, a_ub_wd, a_cnt}); end
    total++; if ({b_busy, b_done, b_fault, b_hit, b_lb_we, b_ub_we, b_cnt} !== 8'b0) begin bad++; $display("FAIL reset_b: got %b want 0", {b_busy, b_done, b_fault, b_hit, b_lb_we, b_ub_we, b_cnt}); end
    a_rst_n = 1; b_rst_n = 1;
    @(posedge clk); #1;
    total++; if ({a_busy, a_done} !== 2'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {a_busy, a_done}); end
  endtask

  task automatic test_word_write();
    sel = 0;
    run(1, 0, 16'h0010, 16'hBEEF, 0); exp_a++;
    total++; if ({slw, suw, lwd, uwd} !== {2'b11, 16'hEFBE}) begin bad++; $display("FAIL ww_lanes: got %b%b %h %h want 11 ef be", slw, suw, lwd, uwd); end
    total++; if ({la, ua} !== 32'h0010_0011) begin bad++; $display("FAIL ww_addr: got %h %h want 0010 0011", la, ua); end
    total++; if (nstb !== 1) begin bad++; $display("FAIL ww_strobe_len: got %0d want 1", nstb); end
    total++; if ({lat, f_o} !== {32'd2, 1'b0}) begin bad++; $display("FAIL ww_latency: got lat=%0d fault=%b want 2 0", lat, f_o); end
    total++; if (a_cnt !== 16'(exp_a)) begin bad++; $display("FAIL ww_count: got %0d want %0d", a_cnt, exp_a); end
  endtask

  task automatic test_reads();
    sel = 0;
    run(0, 0, 16'h0010, 16'h0, 0); exp_a++;
    total++; if (a_rdata !== 16'hBEEF) begin bad++; $display("FAIL word_read: got %h want beef", a_rdata); end
    run(0, 1, 16'h0011, 16'h0, 0); exp_a++;
    total++; if (a_rdata !== 16'h00BE) begin bad++; $display("FAIL byte_read_hi: got %h want 00be", a_rdata); end
    run(1, 1, 16'h0011, 16'h0055, 0); exp_a++;
    total++; if ({slw, suw, uwd} !== {2'b01, 8'h55}) begin bad++; $display("FAIL byte_write_hi: got %b%b %h want 01 55", slw, suw, uwd); end
    total++; if (a_rdata !== 16'h00BE) begin bad++; $display("FAIL write_keeps_rdata: got %h want 00be", a_rdata); end
    run(0, 0, 16'h0010, 16'h0, 0); exp_a++;
    total++; if (a_rdata !== 16'h55EF) begin bad++; $display("FAIL readback: got %h want 55ef", a_rdata); end
  endtask

  task automatic test_misalign();
    sel = 0;
    run(0, 0, 16'h0013, 16'h0, 0);
    total++; if ({lat, f_o} !== {32'd1, 1'b1}) begin bad++; $display("FAIL misalign_done: got lat=%0d fault=%b want 1 1", lat, f_o); end
    total++; if (nstb !== 0) begin bad++; $display("FAIL misalign_strobe: got %0d want 0", nstb); end
    total++; if ({a_rdata, a_cnt} !== {16'h55EF, 16'(exp_a)}) begin bad++; $display("FAIL misalign_state: got %h %0d want 55ef %0d", a_rdata, a_cnt, exp_a); end
    run(1, 0, 16'h0011, 16'hAAAA, 0);
    total++; if ({f_o, nstb} !== {1'b1, 32'd0}) begin bad++; $display("FAIL misalign_write: got fault=%b strobes=%0d want 1 0", f_o, nstb); end
  endtask

  task automatic test_wrap();
    sel = 0;
    run(1, 0, 16'hFFFE, 16'h1234, 0); exp_a++;
    total++; if ({la, ua, slw, suw} !== {32'hFFFE_FFFF, 2'b11}) begin bad++; $display("FAIL top_word: got %h %h %b%b want fffe ffff 11", la, ua, slw, suw); end
    run(1, 1, 16'hFFFF, 16'h0077, 0); exp_a++;
    total++; if ({la, ua, slw, suw, uwd} !== {32'hFFFE_FFFF, 2'b01, 8'h77}) begin bad++; $display("FAIL top_byte: got %h %h %b%b %h want fffe ffff 01 77", la, ua, slw, suw, uwd); end
  endtask

  task automatic test_bkpt();
    sel = 0; bkpt_en = 1; bkpt_mode = 2'b10; bkpt_addr = 16'h0020;
    run(0, 0, 16'h0020, 16'h0, 0); exp_a++;
    total++; if (h_o !== 1'b0) begin bad++; $display("FAIL bk_read_wmode: got %b want 0", h_o); end
    run(1, 0, 16'h0020, 16'h1111, 0); exp_a++;
    total++; if ({h_o, a_done} !== 2'b11) begin bad++; $display("FAIL bk_write: got hit=%b done=%b want 11", h_o, a_done); end
    @(posedge clk); #1;
    total++; if (a_hit !== 1'b0) begin bad++; $display("FAIL bk_pulse: got %b want 0", a_hit); end
    run(1, 1, 16'h0021, 16'h0022, 0); exp_a++;
    total++; if (h_o !== 1'b0) begin bad++; $display("FAIL bk_byte_odd: got %b want 0", h_o); end
    run(1, 0, 16'h0021, 16'h0, 0);
    total++; if ({h_o, f_o} !== 2'b01) begin bad++; $display("FAIL bk_fault: got hit=%b fault=%b want 01", h_o, f_o); end
    bkpt_mode = 2'b11;
    run(0, 1, 16'h0020, 16'h0, 0); exp_a++;
    total++; if (h_o !== 1'b1) begin bad++; $display("FAIL bk_either: got %b want 1", h_o); end
    bkpt_en = 0;
    run(1, 0, 16'h0020, 16'h0, 0); exp_a++;
    total++; if (h_o !== 1'b0) begin bad++; $display("FAIL bk_disabled: got %b want 0", h_o); end
  endtask

  task automatic test_random();
    logic w, b, ef, eh, elw, euw;
    logic [15:0] ad, wd, erd;
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom);
      ref_a[16'h0100 + 16'(2 * i)] = wd[7:0]; ref_a[16'h0101 + 16'(2 * i)] = wd[15:8];
      run(1, 0, 16'h0100 + 16'(2 * i), wd, 0); exp_a++;
    end
    run(0, 0, 16'h0100, 16'h0, 0); exp_a++;
    erd = {ref_a[16'h0101], ref_a[16'h0100]};
    total++; if (a_rdata !== erd) begin bad++; $display("FAIL rnd_first_read: got %h want %h", a_rdata, erd); end
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom); b = 1'($urandom); ad = 16'h0100 + 16'($urandom_range(0, 31)); wd = 16'($urandom);
      bkpt_en = 1'($urandom); bkpt_mode = 2'($urandom); bkpt_addr = 16'h0100 + 16'($urandom_range(0, 31));
      ef = !b && ad[0];
      eh = bkpt_en && !ef && (ad[15:1] == bkpt_addr[15:1]) && (!b || ad[0] == bkpt_addr[0]) && (w ? bkpt_mode[1] : bkpt_mode[0]);
      elw = !ef && w && (!b || !ad[0]);
      euw = !ef && w && (!b || ad[0]);
      if (!ef) exp_a++;
      if (!ef && !w) erd = b ? {8'h00, ref_a[ad]} : {ref_a[ad + 16'd1], ref_a[ad]};
      if (!ef && w) begin
        ref_a[ad] = wd[7:0];
        if (!b) ref_a[ad + 16'd1] = wd[15:8];
      end
      run(w, b, ad, wd, 0);
      total++; if ({lat, f_o, h_o} !== {(ef ? 32'd1 : 32'd2), ef, eh}) begin bad++; $display("FAIL rnd_ctrl[%0d]: got lat=%0d f=%b h=%b want %0d %b %b", i, lat, f_o, h_o, ef ? 1 : 2, ef, eh); end
      total++; if ({slw, suw} !== {elw, euw}) begin bad++; $display("FAIL rnd_strobe[%0d]: got %b%b want %b%b", i, slw, suw, elw, euw); end
      total++; if ({a_rdata, a_cnt} !== {erd, 16'(exp_a)}) begin bad++; $display("FAIL rnd_data[%0d]: got %h %0d want %h %0d", i, a_rdata, a_cnt, erd, exp_a); end
    end
    bkpt_en = 0;
  endtask

  task automatic test_back_to_back();
    int cyc = 0, d1 = 0, d2 = 0;
    sel = 1;
    @(posedge clk); #1;
    we = 0; byte_acc = 0; addr = 16'h0040; b_req = 1;
    while (cyc < 40 && d2 == 0) begin
      @(posedge clk); #1; cyc++;
      if (b_done) begin if (d1 == 0) d1 = cyc; else d2 = cyc; end
    end
    b_req = 0;
    total++; if (d1 !== 5) begin bad++; $display("FAIL ws_latency: got %0d want 5", d1); end
    total++; if (d2 - d1 !== 6) begin bad++; $display("FAIL ws_throughput: got %0d want 6", d2 - d1); end
    total++; if (b_cnt !== 2'd2) begin bad++; $display("FAIL ws_count: got %0d want 2", b_cnt); end
  endtask

  task automatic test_saturation();
    sel = 1;
    run(0, 0, 16'h0040, 16'h0, 0);
    total++; if ({lat, b_cnt} !== {32'd5, 2'd3}) begin bad++; $display("FAIL sat_3: got lat=%0d cnt=%0d want 5 3", lat, b_cnt); end
    run(1, 0, 16'h0040, 16'h4242, 0);
    total++; if (b_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", b_cnt); end
    run(0, 0, 16'h0040, 16'h0, 5);
    total++; if (b_cnt !== 2'd0) begin bad++; $display("FAIL clr_wins: got %0d want 0", b_cnt); end
    total++; if (b_rdata !== 16'h4242) begin bad++; $display("FAIL ws_rdata: got %h want 4242", b_rdata); end
    run(0, 1, 16'h0041, 16'h0, 0);
    total++; if ({b_cnt, b_rdata} !== {2'd1, 16'h0042}) begin bad++; $display("FAIL after_clr: got %0d %h want 1 0042", b_cnt, b_rdata); end
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    sel = 1;
    @(posedge clk); #1;
    we = 1; byte_acc = 0; addr = 16'h0060; wdata = 16'hCAFE; b_req = 1;
    @(posedge clk); #1; b_req = 0;
    total++; if ({b_lb_we, b_ub_we, b_busy} !== 3'b111) begin bad++; $display("FAIL mid_access: got %b want 111", {b_lb_we, b_ub_we, b_busy}); end
    @(posedge clk); #2;
    b_rst_n = 0; #1;
    total++; if ({b_busy, b_done, b_fault, b_hit, b_lb_we, b_ub_we, b_cnt} !== 8'b0) begin bad++; $display("FAIL mid_reset_flags: got %b want 0", {b_busy, b_done, b_fault, b_hit, b_lb_we, b_ub_we, b_cnt}); end
    total++; if ({b_rdata, b_lb_addr, b_ub_addr, b_lb_wd, b_ub_wd} !== 64'h0) begin bad++; $display("FAIL mid_reset_data: got %h want 0", {b_rdata, b_lb_addr, b_ub_addr, b_lb_wd, b_ub_wd}); end
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; seen |= b_done; end
    b_rst_n = 1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seen |= b_done; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_done: got %b want 0", seen); end
    run(0, 0, 16'h0040, 16'h0, 0);
    total++; if ({lat, b_cnt} !== {32'd5, 2'd1}) begin bad++; $display("FAIL post_reset: got lat=%0d cnt=%0d want 5 1", lat, b_cnt); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_reads();
    test_misalign();
    test_wrap();
    test_bkpt();
    test_random();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
